// File: rtl/rand_packer.sv
//==============================================================================
// Module      : rand_packer
// Description : Packs WIDTH-bit LFSR beats into OUT_WIDTH-bit words (first
//               beat least significant) and buffers them in a small in-order
//               FIFO with a valid/ready output. Words completing while the
//               FIFO is full are dropped and counted in a saturating counter.
//               Optional feature macro: RAND_PACKER_REJECT_EN. When defined,
//               completed words >= LIMIT are silently discarded.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module rand_packer #(
    parameter int                   WIDTH      = 16,
    parameter int                   OUT_WIDTH  = 32,
    parameter int                   FIFO_DEPTH = 4,
    parameter logic [OUT_WIDTH-1:0] LIMIT      = 32'h8000_0000
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [WIDTH-1:0]                  in_data,
    input  logic                              in_valid,
    output logic [OUT_WIDTH-1:0]              out_data,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   level,
    output logic [15:0]                       drop_count
);

    localparam int c_R  = OUT_WIDTH / WIDTH;
    localparam int c_BW = (c_R > 1) ? $clog2(c_R) : 1;
    localparam int c_AW = $clog2(FIFO_DEPTH);
    localparam int c_LW = $clog2(FIFO_DEPTH + 1);

    logic [c_BW-1:0]      r_beat;
    logic [OUT_WIDTH-1:0] r_partial;
    logic [OUT_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [c_AW-1:0]      r_wptr;
    logic [c_AW-1:0]      r_rptr;
    logic [c_LW-1:0]      r_level;
    logic                 r_out_valid;
    logic [OUT_WIDTH-1:0] r_out_data;
    logic [15:0]          r_drop;

    logic [OUT_WIDTH-1:0] w_word;
    logic                 w_last;
    logic                 w_complete;
    logic                 w_limit_ok;
    logic                 w_pop;
    logic                 w_has_room;
    logic                 w_push;
    logic                 w_drop;
    logic [c_AW-1:0]      w_rptr_n;
    logic [c_LW-1:0]      w_level_after_pop;
    logic [c_LW-1:0]      w_level_n;
    logic [OUT_WIDTH-1:0] w_head_n;

    // Candidate word: stored partial beats with the current beat dropped into its slot
    always_comb begin
        w_word = r_partial;
        for (int k = 0; k < c_R; k++) begin
            if (r_beat == c_BW'(k)) begin
                w_word[k*WIDTH +: WIDTH] = in_data;
            end
        end
    end

    assign w_last     = (r_beat == c_BW'(c_R - 1));
    assign w_complete = in_valid & w_last;

`ifdef RAND_PACKER_REJECT_EN
    assign w_limit_ok = (w_word < LIMIT);
`else
    // LIMIT is ignored in this build; the expression is constant true
    assign w_limit_ok = (LIMIT == LIMIT);
`endif

    // Pop uses the registered valid, so out_ready only reaches the push/drop decision
    assign w_pop      = r_out_valid & out_ready;
    assign w_has_room = (r_level < c_LW'(FIFO_DEPTH)) | w_pop;
    assign w_push     = w_complete & w_limit_ok & w_has_room;
    assign w_drop     = w_complete & w_limit_ok & ~w_has_room;

    // Next occupancy, read pointer and head word for the registered outputs
    always_comb begin
        w_level_after_pop = r_level - c_LW'(w_pop);
        w_level_n         = w_level_after_pop + c_LW'(w_push);
        w_rptr_n          = r_rptr + c_AW'(w_pop);
        if (w_level_n == '0) begin
            w_head_n = '0;
        end else if (w_level_after_pop == '0) begin
            // FIFO drains to empty this edge, so the new head is the word being pushed
            w_head_n = w_word;
        end else begin
            w_head_n = r_mem[w_rptr_n];
        end
    end

    // FIFO storage: contents need no reset, occupancy tracks validity
    always_ff @(posedge clk) begin
        if (w_push && !rst) begin
            r_mem[r_wptr] <= w_word;
        end
    end

    // Beat assembly, FIFO pointers, registered outputs and drop counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_beat      <= '0;
            r_partial   <= '0;
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_level     <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_drop      <= '0;
        end else begin
            if (in_valid) begin
                r_beat    <= w_last ? '0 : r_beat + c_BW'(1);
                r_partial <= w_word;
            end
            if (w_push) begin
                r_wptr <= r_wptr + c_AW'(1);
            end
            r_rptr      <= w_rptr_n;
            r_level     <= w_level_n;
            r_out_valid <= (w_level_n != '0);
            r_out_data  <= w_head_n;
            if (w_drop && (r_drop != 16'hFFFF)) begin
                r_drop <= r_drop + 16'd1;
            end
        end
    end

    assign out_data   = r_out_data;
    assign out_valid  = r_out_valid;
    assign level      = r_level;
    assign drop_count = r_drop;

endmodule

`default_nettype wire

// File: tb/tb_rand_packer.sv
//==============================================================================
// Module      : tb_rand_packer
// Description : Self-checking bench for rand_packer with default parameters
//               (WIDTH=16, OUT_WIDTH=32, FIFO_DEPTH=4). A queue model of the
//               FIFO holds expected words; table vectors and hand sequences
//               add explicit expectations for the corner cases.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_rand_packer;

    logic        clk;
    logic        rst;
    logic [15:0] in_data;
    logic        in_valid;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  level;
    logic [15:0] drop_count;

    int n_checks;
    int n_errors;

    // Reference model state
    logic [31:0] m_q[$];
    logic        m_beat;
    logic [15:0] m_part;
    logic [15:0] m_drop;

    typedef struct {
        logic        v;
        logic [15:0] d;
        logic        rdy;
        logic        e_valid;
        logic [31:0] e_data;
        logic [2:0]  e_level;
        logic [15:0] e_drop;
    } vec_t;

    vec_t vecs[9];

    rand_packer dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .level      (level),
        .drop_count (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Apply one cycle of stimulus, advance the model at the edge, compare at negedge
    task automatic step(input logic v, input logic [15:0] d, input logic rdy, input logic rs);
        logic        pop;
        logic [31:0] word;
        logic [31:0] unused_w;
        in_valid  = v;
        in_data   = d;
        out_ready = rdy;
        rst       = rs;
        // Scoreboard: a handshake is about to take the head word
        if (!rs && rdy && out_valid) begin
            if (m_q.size() == 0) chk("pop_unexpected", 32'd1, 32'd0);
            else                 chk("pop_word", out_data, m_q[0]);
        end
        @(posedge clk);
        if (rs) begin
            m_q.delete();
            m_beat = 1'b0;
            m_part = '0;
            m_drop = '0;
        end else begin
            pop = (m_q.size() != 0) && rdy;
            if (pop) unused_w = m_q.pop_front();
            if (v && m_beat) begin
                word = {d, m_part};
`ifdef RAND_PACKER_REJECT_EN
                if (word < 32'h8000_0000) begin
`else
                begin
`endif
                    if (m_q.size() < 4) m_q.push_back(word);
                    else if (m_drop != 16'hFFFF) m_drop++;
                end
            end
            if (v) begin
                m_part = d;
                m_beat = ~m_beat;
            end
        end
        @(negedge clk);
        chk("model_valid", {31'd0, out_valid}, {31'd0, m_q.size() != 0});
        chk("model_data",  out_data, (m_q.size() != 0) ? m_q[0] : 32'd0);
        chk("model_level", {29'd0, level}, 32'(m_q.size()));
        chk("model_drop",  {16'd0, drop_count}, {16'd0, m_drop});
    endtask

    task automatic put_word(input logic [31:0] w, input logic rdy);
        step(1'b1, w[15:0],  rdy, 1'b0);
        step(1'b1, w[31:16], rdy, 1'b0);
    endtask

    initial begin
        logic [31:0] ow[5];
        n_checks = 0;
        n_errors = 0;
        m_beat = 1'b0;
        m_part = '0;
        m_drop = '0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0; rst = 1'b1;
        @(negedge clk);
        step(1'b0, 16'h0, 1'b0, 1'b1);
        step(1'b0, 16'h0, 1'b0, 1'b1);

        // Reset state
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_data",  out_data, 32'd0);
        chk("rst_level", {29'd0, level}, 32'd0);
        chk("rst_drop",  {16'd0, drop_count}, 32'd0);

        // Basic packing and input gaps
        vecs[0] = '{1'b1, 16'h1111, 1'b1, 1'b0, 32'h0000_0000, 3'd0, 16'd0};
        vecs[1] = '{1'b1, 16'h2222, 1'b1, 1'b1, 32'h2222_1111, 3'd1, 16'd0};
        vecs[2] = '{1'b0, 16'h0000, 1'b1, 1'b0, 32'h0000_0000, 3'd0, 16'd0};
        vecs[3] = '{1'b1, 16'hAAAA, 1'b1, 1'b0, 32'h0000_0000, 3'd0, 16'd0};
        vecs[4] = '{1'b0, 16'h5555, 1'b1, 1'b0, 32'h0000_0000, 3'd0, 16'd0};
        vecs[5] = '{1'b0, 16'h5555, 1'b1, 1'b0, 32'h0000_0000, 3'd0, 16'd0};
        vecs[6] = '{1'b0, 16'h5555, 1'b1, 1'b0, 32'h0000_0000, 3'd0, 16'd0};
        vecs[7] = '{1'b1, 16'hBBBB, 1'b1, 1'b1, 32'hBBBB_AAAA, 3'd1, 16'd0};
        vecs[8] = '{1'b0, 16'h0000, 1'b1, 1'b0, 32'h0000_0000, 3'd0, 16'd0};
        for (int i = 0; i < 9; i++) begin
            step(vecs[i].v, vecs[i].d, vecs[i].rdy, 1'b0);
            chk($sformatf("vec%0d_valid", i), {31'd0, out_valid}, {31'd0, vecs[i].e_valid});
            chk($sformatf("vec%0d_data", i),  out_data, vecs[i].e_data);
            chk($sformatf("vec%0d_level", i), {29'd0, level}, {29'd0, vecs[i].e_level});
            chk($sformatf("vec%0d_drop", i),  {16'd0, drop_count}, {16'd0, vecs[i].e_drop});
        end

        // Overflow: five words into a four-deep FIFO with the consumer stalled
        for (int i = 0; i < 5; i++) begin
            ow[i] = $urandom();
            put_word(ow[i], 1'b0);
        end
        chk("ovf_level", {29'd0, level}, 32'd4);
        chk("ovf_drop",  {16'd0, drop_count}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("ovf_out%0d", i), out_data, ow[i]);
            step(1'b0, 16'h0, 1'b1, 1'b0);
        end
        chk("ovf_empty_level", {29'd0, level}, 32'd0);
        chk("ovf_empty_valid", {31'd0, out_valid}, 32'd0);

        // Full FIFO with a pop on the same edge as a completion
        for (int i = 0; i < 4; i++) begin
            ow[i] = 32'hC000_0000 + 32'(i);
            put_word(ow[i], 1'b0);
        end
        ow[4] = 32'h5A5A_0F0F;
        step(1'b1, ow[4][15:0], 1'b0, 1'b0);
        step(1'b1, ow[4][31:16], 1'b1, 1'b0);
        chk("fullpop_level", {29'd0, level}, 32'd4);
        chk("fullpop_drop",  {16'd0, drop_count}, 32'd1);
        for (int i = 1; i < 5; i++) begin
            chk($sformatf("fullpop_out%0d", i), out_data, ow[i]);
            step(1'b0, 16'h0, 1'b1, 1'b0);
        end
        chk("fullpop_empty", {29'd0, level}, 32'd0);

        // Reset in the middle of a word
        step(1'b1, 16'hDEAD, 1'b1, 1'b0);
        step(1'b1, 16'hFFFF, 1'b1, 1'b1);
        chk("midrst_drop", {16'd0, drop_count}, 32'd0);
        put_word(32'h0002_0001, 1'b0);
        chk("midrst_data",  out_data, 32'h0002_0001);
        chk("midrst_level", {29'd0, level}, 32'd1);
        step(1'b0, 16'h0, 1'b1, 1'b0);

        // Rejection bound
        put_word(32'hFFFF_0000, 1'b1);
`ifdef RAND_PACKER_REJECT_EN
        chk("rej_first_valid", {31'd0, out_valid}, 32'd0);
`else
        chk("rej_first_data", out_data, 32'hFFFF_0000);
`endif
        put_word(32'h0000_1234, 1'b1);
        chk("rej_second_data", out_data, 32'h0000_1234);
        chk("rej_drop", {16'd0, drop_count}, 32'd0);
        step(1'b0, 16'h0, 1'b1, 1'b0);
        chk("rej_empty", {29'd0, level}, 32'd0);

        // Random free-running traffic against the model
        for (int i = 0; i < 300; i++) begin
            step(1'($urandom_range(0, 3) != 0), 16'($urandom()), 1'($urandom_range(0, 1)), 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/rand_packer.md
# rand_packer

Packs the per-cycle bit vector from the parallel LFSR bank into wide random words and buffers them for the particle-push pipeline. Each accepted input beat contributes WIDTH bits. OUT_WIDTH/WIDTH beats form one word. Completed words go into a small FIFO with a valid/ready output, so downstream stalls do not stop the free-running generator. Words that arrive while the FIFO is full are dropped and counted.

## Interface
- WIDTH, 16: input beat width; equals the LFSR bank's lane count.
- OUT_WIDTH, 32: output word width; must be an integer multiple R = OUT_WIDTH/WIDTH ≥ 1.
- FIFO_DEPTH, 4: output FIFO entries; power of two, ≥ 2.
- LIMIT, 32'h8000_0000: OUT_WIDTH-bit rejection bound; used only when RAND_PACKER_REJECT_EN is defined.
- clk  in  1  sole clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- in_data  in  WIDTH  random bits from the LFSR bank.
- in_valid  in  1  beat qualifier; tie high for a free-running LFSR.
- out_data  out  OUT_WIDTH  FIFO head word; 0 whenever out_valid=0.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  consumer accepts the head when out_valid & out_ready.
- level  out  $clog2(FIFO_DEPTH+1)  current FIFO occupancy.
- drop_count  out  16  saturating count of words lost to a full FIFO.

## Operation
- **Beat counter** `beat` runs 0..R-1 and advances only on edges where in_valid=1.
- **Word assembly:** the k-th accepted beat of a word occupies bits [WIDTH*(k+1)-1 : WIDTH*k], so the first beat is least significant.
- **Word completion:** a word completes on the edge where in_valid=1 and beat=R-1. The candidate word is the partial register combined with the current in_data, and beat returns to 0.
- **Pop:** occurs when out_valid & out_ready.
- **Push:** occurs on word completion when level<FIFO_DEPTH, or when level=FIFO_DEPTH and a pop happens on the same edge.
- **Drop:** a completed word that cannot be pushed is discarded, and drop_count increments. drop_count saturates at 16'hFFFF.
- **Ordering:** the FIFO is strictly in order. level changes by +1 (push only), −1 (pop only) or 0 (both or neither).
- **Reset values:** out_valid=0, out_data=0, level=0, drop_count=0, beat=0. The partial word and FIFO contents are discarded.
- **Reset mid-operation:** rst overrides every in_valid and out_ready on that edge. The first beat accepted after reset starts a new word.

## Timing
- **Latency:** out_valid rises on the edge after the completing beat. For R=2, beats accepted at edges n and n+1 give out_valid=1 after edge n+1, i.e. visible in cycle n+2.
- **Throughput:** at most one word per R input beats. The output sustains one word per cycle while the FIFO is non-empty.
- **Output registers:** out_data, out_valid and level are registered, with no combinational path from in_* to out_*.
- **Ready path:** out_ready may combinationally affect only the push-when-full decision. It has no combinational path to any output.
- **Handshake rules:** out_data is held stable while out_valid=1 and out_ready=0. The consumer may drop out_ready at any time.
- **Drop accounting:** drop_count updates on the same edge as the dropped completion.

## Configuration
- **RAND_PACKER_REJECT_EN defined:** a completed word with value ≥ LIMIT (unsigned) is discarded silently. It is neither pushed nor counted in drop_count. Rejection is evaluated before the full check, so a rejected word never counts as a drop. Accepted words are therefore uniform on [0, LIMIT).
- **Not defined:** LIMIT is ignored and every completed word is a push candidate.

## Test plan
- **Basic packing** (WIDTH=16, OUT_WIDTH=32, out_ready=1): beats 16'h1111, 16'h2222 on consecutive edges -> out_valid=1 for one cycle with out_data=32'h2222_1111, then out_valid=0 and level=0.
- **Input gaps:** beat 16'hAAAA, in_valid=0 for 3 cycles, then beat 16'hBBBB -> single word 32'hBBBB_AAAA; idle cycles add no bits.
- **Overflow** (out_ready=0, FIFO_DEPTH=4): complete 5 words W0..W4 -> level=4, drop_count=1; then out_ready=1 -> W0,W1,W2,W3 on 4 consecutive cycles, level=0, W4 never appears.
- **Full with simultaneous pop:** level=4, a word completes on the same edge as a pop -> level stays 4, drop_count unchanged, new word appears fifth in order.
- **Reset mid-word:** beat 16'hDEAD, rst for one cycle, then beats 16'h0001, 16'h0002 -> out_data=32'h0002_0001, drop_count=0.
- **Rejection** (macro defined, LIMIT=32'h8000_0000): words 32'hFFFF_0000 then 32'h0000_1234 -> only 32'h0000_1234 is output, drop_count=0. Without the macro, both words are output in order.
